// File: rtl/mdu_if.sv
// mdu_if: request/response bundle between E-stage control and the multiply/divide unit.
// Handshake: `start` is a one-cycle request strobe qualified by `op`, `A`
// and `B`. It is only honoured while `busy` is low, so `!busy` plays the
// role of ready. A request with a long op is accepted at the edge where
// start && !busy, after which `busy` stays high for the fixed latency. New
// HI/LO appear in the same cycle that `busy` falls. Requests made while
// `busy` is high are dropped, not queued.
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (output start, op, A, B, input busy, HI, LO);
    modport slave  (input start, op, A, B, output busy, HI, LO);
endinterface

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with HI/LO registers.
// The result is computed at accept time and held in tHI/tLO. It is committed
// to HI/LO after MULT_CYCLES or DIV_CYCLES cycles of `busy`.
// Optional feature: define MDU_MADD_EN to enable op 7 (madd, signed
// multiply-accumulate into {HI,LO}). Without it, op 7 behaves like op 0.
module mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus,
    output logic  dbg_state_o   // 1 while the FSM is in RUN
);
    localparam int MAXC  = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'd7;
`endif

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] thi_q, tlo_q;

    logic             long_op;
    logic [CNT_W-1:0] lat_d;
    logic [WIDTH-1:0] thi_d, tlo_d;

    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [WIDTH-1:0]   quot_s, rem_s, quot_u, rem_u;

    // Operands are widened before multiplying so the full 64-bit product is kept.
    assign prod_s = $signed({{WIDTH{bus.A[WIDTH-1]}}, bus.A}) *
                    $signed({{WIDTH{bus.B[WIDTH-1]}}, bus.B});
    assign prod_u = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
    // Signed / and % truncate toward zero; the remainder follows the dividend's sign.
    assign quot_s = $signed(bus.A) / $signed(bus.B);
    assign rem_s  = $signed(bus.A) % $signed(bus.B);
    assign quot_u = bus.A / bus.B;
    assign rem_u  = bus.A % bus.B;

    // Decode the requested op into latency and the result to be latched in tHI/tLO.
    always_comb begin
        long_op = 1'b0;
        lat_d   = '0;
        thi_d   = hi_q;   // divide by zero keeps HI/LO, which cannot change during RUN
        tlo_d   = lo_q;
        case (bus.op)
            OP_MULT: begin
                long_op        = 1'b1;
                lat_d          = CNT_W'(MULT_CYCLES);
                {thi_d, tlo_d} = prod_s;
            end
            OP_MULTU: begin
                long_op        = 1'b1;
                lat_d          = CNT_W'(MULT_CYCLES);
                {thi_d, tlo_d} = prod_u;
            end
            OP_DIV: begin
                long_op = 1'b1;
                lat_d   = CNT_W'(DIV_CYCLES);
                if (bus.B != '0) begin
                    thi_d = rem_s;
                    tlo_d = quot_s;
                end
            end
            OP_DIVU: begin
                long_op = 1'b1;
                lat_d   = CNT_W'(DIV_CYCLES);
                if (bus.B != '0) begin
                    thi_d = rem_u;
                    tlo_d = quot_u;
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                long_op        = 1'b1;
                lat_d          = CNT_W'(MULT_CYCLES);
                {thi_d, tlo_d} = {hi_q, lo_q} + prod_s;
            end
`endif
            default: ;
        endcase
    end

    // IDLE/RUN control FSM with registered busy and HI/LO commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            thi_q   <= '0;
            tlo_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (long_op) begin
                            thi_q   <= thi_d;
                            tlo_q   <= tlo_d;
                            cnt_q   <= lat_d;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end else if (bus.op == OP_MTHI) begin
                            hi_q <= bus.A;
                        end else if (bus.op == OP_MTLO) begin
                            lo_q <= bus.A;
                        end
                    end
                end
                RUN: begin
                    if (cnt_q == CNT_W'(1)) begin
                        hi_q    <= thi_q;
                        lo_q    <= tlo_q;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.HI      = hi_q;
    assign bus.LO      = lo_q;
    assign dbg_state_o = (state_q == RUN);
endmodule
